ace_snoop_responder: RTL
========================

# ace_snoop_responder

Snoop-side slave of the L1 cache: accepts ACE snoop requests on AC, looks up the cache tag/state/data arrays, and answers on CR and CD. It applies the MOESI state change for each request. It sits directly downstream of the interconnect's AC/CR/CD channels and beside the cache controller. It asserts `snoop_busy` so the controller stalls CPU accesses while a snoop is in flight.

## Interface
- `WIDTH_A`, 32, address width
- `WIDTH_D`, 32, data width (one line = one beat)
- `WIDTH_STATE`, 3, line state width; I=000, S=001, E=010, O=011, M=100
- Clock/reset: one clock; reset is asynchronous and active-high.
- `clk` in 1 clock, all logic on rising edge
- `rst` in 1 asynchronous active-high reset
- `AC_VALID` in 1 snoop request valid
- `AC_READY` out 1 snoop request accepted
- `AC_ADDR` in WIDTH_A snoop address
- `AC_SNOOP` in 4 snoop opcode
- `AC_PROT` in 3 ignored
- `CR_VALID` out 1 snoop response valid
- `CR_READY` in 1 interconnect takes response
- `CR_RESP` out 5 {WasUnique, IsShared, PassDirty, Error, DataTransfer}
- `CD_VALID` out 1 snoop data valid
- `CD_READY` in 1 interconnect takes data
- `CD_DATA` out WIDTH_D line data
- `CD_LAST` out 1 last beat, =CD_VALID (single beat)
- `lk_valid` out 1 array lookup strobe
- `lk_addr` out WIDTH_A lookup address
- `lk_hit` in 1 tag match, valid the cycle after `lk_valid`
- `lk_state` in WIDTH_STATE line state, same timing as `lk_hit`
- `lk_data` in WIDTH_D line data, same timing as `lk_hit`
- `upd_valid` out 1 one-cycle state write strobe
- `upd_addr` out WIDTH_A address to update
- `upd_state` out WIDTH_STATE new state
- `snoop_busy` out 1 high in every state except IDLE

## Operation
- FSM states: IDLE, LOOKUP, EVAL, RESP, DATA, UPDATE.
- IDLE
  - AC_READY=1.
  - When AC_VALID and AC_READY are both high at an edge, latch AC_ADDR/AC_SNOOP.
  - Supported opcode → LOOKUP; unsupported opcode → RESP.
- LOOKUP: lk_valid=1, lk_addr=latched address; → EVAL.
- EVAL
  - Sample lk_hit/lk_state/lk_data at the closing edge.
  - Compute CR_RESP, the next state and the need for data; → RESP.
- RESP
  - Hold CR_VALID=1 until CR_READY.
  - Then → DATA if DataTransfer=1, else → UPDATE if a state change is pending, else → IDLE.
- DATA
  - Hold CD_VALID=CD_LAST=1, CD_DATA=sampled line, until CD_READY.
  - Then → UPDATE if a state change is pending, else → IDLE.
- UPDATE: upd_valid=1 for one cycle; → IDLE.
- Hit rules (miss, or lk_state=I: CR_RESP=00000, no data, no update):
  - WasUnique = (state is E or M), for every hit.
  - ReadOnce 0000: DT=1, IsShared=1, no state change.
  - ReadShared 0001: DT=1, IsShared=1. M→O, E→S, S and O unchanged.
  - ReadUnique 0111: DT=1, PassDirty=(M or O), next state I.
  - CleanInvalid 1001: if M or O then DT=1 and PassDirty=1; next state I.
  - MakeInvalid 1101: no data, next state I, WasUnique forced 0.
- An update is issued only when the new state differs from the old state.
- Unsupported opcodes: no lookup, no update, CR_RESP=00000.

## Timing
- Reset values:
  - AC_READY=0 during reset, 1 on the first cycle after reset.
  - All other outputs 0.
- Latency: AC handshake at edge 0 → lk_valid high in cycle 1 → CR_VALID high from edge 3.
- CD_VALID rises the cycle after the CR handshake; upd_valid rises the cycle after the final handshake.
- CR_READY or CD_READY already high when its VALID rises: the handshake completes in that first cycle.
- VALID and payload stay stable until the handshake. CR and CD are never asserted together.
- AC_READY=0 outside IDLE; back-to-back snoops are accepted no sooner than the cycle after returning to IDLE.
- Reset mid-operation: FSM → IDLE, the in-flight snoop is dropped, and no upd_valid is issued.

## Configuration
- `SNOOP_ERR_EN`
  - Defined: unsupported AC_SNOOP codes respond CR_RESP=00010 (Error).
  - Undefined: unsupported codes respond 00000.
  - Supported-opcode behaviour is identical either way.

## Test plan
- ReadShared 0x8, lk_hit=1, state M, data FACEFABE, CR_READY=CD_READY=1:
  - CR_RESP=11001 at edge 3, then CD_DATA=FACEFABE with CD_LAST=1.
  - Then upd_valid with upd_state=O (011).
- ReadUnique 0xC, state O, data DEADBEEF:
  - CR_RESP=00101, CD_DATA=DEADBEEF, upd_state=I.
- ReadShared 0x0, lk_hit=0:
  - CR_RESP=00000, no CD_VALID, no upd_valid, AC_READY back within 5 cycles of the handshake.
- CleanInvalid, state E, CR_READY held low for 4 cycles:
  - CR_VALID and CR_RESP=10000 held stable all 4 cycles.
  - No CD_VALID, then upd_state=I.
- Opcode 1111:
  - No lk_valid.
  - CR_RESP=00010 with SNOOP_ERR_EN defined, 00000 without.
- rst pulsed while CD_VALID=1:
  - All outputs 0 during reset, AC_READY=1 after release, no upd_valid pulse.

Source files
------------

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder
// Snoop-side slave of the L1 cache. It accepts one ACE snoop at a time on AC,
// looks the line up in the cache arrays, answers on CR (and CD when data is
// passed), and writes back the MOESI state change when one is needed.
//
// Optional feature macro: SNOOP_ERR_EN
//   defined   -> unsupported AC_SNOOP codes answer CR_RESP=00010 (Error)
//   undefined -> unsupported AC_SNOOP codes answer CR_RESP=00000
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   AC_*                     snoop request channel (AC_PROT unused)
//   CR_*                     snoop response {WasUnique,IsShared,PassDirty,Error,DataTransfer}
//   CD_*                     single-beat snoop data
//   lk_valid/lk_addr         array lookup strobe and address
//   lk_hit/lk_state/lk_data  lookup result, valid the cycle after lk_valid
//   upd_valid/addr/state     one-cycle line state write
//   snoop_busy               high whenever a snoop is in flight
//
// state  | meaning
// IDLE   | ready for a new snoop
// LOOKUP | lookup strobe to the arrays
// EVAL   | lookup result sampled, response computed
// RESP   | CR_VALID held until CR_READY
// DATA   | CD_VALID held until CD_READY
// UPDATE | one-cycle state write strobe
module ace_snoop_responder #(
  parameter int WIDTH_A     = 32,
  parameter int WIDTH_D     = 32,
  parameter int WIDTH_STATE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   AC_VALID,
  output logic                   AC_READY,
  input  logic [WIDTH_A-1:0]     AC_ADDR,
  input  logic [3:0]             AC_SNOOP,
  input  logic [2:0]             AC_PROT,
  output logic                   CR_VALID,
  input  logic                   CR_READY,
  output logic [4:0]             CR_RESP,
  output logic                   CD_VALID,
  input  logic                   CD_READY,
  output logic [WIDTH_D-1:0]     CD_DATA,
  output logic                   CD_LAST,
  output logic                   lk_valid,
  output logic [WIDTH_A-1:0]     lk_addr,
  input  logic                   lk_hit,
  input  logic [WIDTH_STATE-1:0] lk_state,
  input  logic [WIDTH_D-1:0]     lk_data,
  output logic                   upd_valid,
  output logic [WIDTH_A-1:0]     upd_addr,
  output logic [WIDTH_STATE-1:0] upd_state,
  output logic                   snoop_busy
);

  localparam logic [WIDTH_STATE-1:0] ST_I = WIDTH_STATE'(0);
  localparam logic [WIDTH_STATE-1:0] ST_S = WIDTH_STATE'(1);
  localparam logic [WIDTH_STATE-1:0] ST_E = WIDTH_STATE'(2);
  localparam logic [WIDTH_STATE-1:0] ST_O = WIDTH_STATE'(3);
  localparam logic [WIDTH_STATE-1:0] ST_M = WIDTH_STATE'(4);

  localparam logic [3:0] OP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] OP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] OP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] OP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] OP_MAKE_INVALID  = 4'b1101;

`ifdef SNOOP_ERR_EN
  localparam logic [4:0] RESP_UNSUP = 5'b00010;
`else
  localparam logic [4:0] RESP_UNSUP = 5'b00000;
`endif

  typedef enum logic [2:0] {IDLE, LOOKUP, EVAL, RESP, DATA, UPDATE} state_t;

  state_t state, state_nxt;

  logic [WIDTH_A-1:0]     addr_q;
  logic [3:0]             snoop_q;
  logic [4:0]             resp_q;
  logic [WIDTH_D-1:0]     data_q;
  logic [WIDTH_STATE-1:0] nst_q;
  logic                   pend_q;

  logic                   supported;
  logic                   hit;
  logic                   was_unique;
  logic                   dirty;
  logic [4:0]             ev_resp;
  logic [WIDTH_STATE-1:0] ev_nst;
  logic                   ev_pend;
  logic                   unused_prot;

  assign unused_prot = ^AC_PROT;

  assign supported = (AC_SNOOP == OP_READ_ONCE)     || (AC_SNOOP == OP_READ_SHARED) ||
                     (AC_SNOOP == OP_READ_UNIQUE)   || (AC_SNOOP == OP_CLEAN_INVALID) ||
                     (AC_SNOOP == OP_MAKE_INVALID);

  // Response and MOESI successor for the latched opcode against the lookup result.
  always_comb begin
    hit        = lk_hit && (lk_state != ST_I);
    was_unique = (lk_state == ST_E) || (lk_state == ST_M);
    dirty      = (lk_state == ST_M) || (lk_state == ST_O);
    ev_resp    = 5'b00000;
    ev_nst     = lk_state;
    if (hit) begin
      case (snoop_q)
        OP_READ_ONCE:   ev_resp = {was_unique, 1'b1, 1'b0, 1'b0, 1'b1};
        OP_READ_SHARED: begin
          ev_resp = {was_unique, 1'b1, 1'b0, 1'b0, 1'b1};
          if (lk_state == ST_M)      ev_nst = ST_O;
          else if (lk_state == ST_E) ev_nst = ST_S;
        end
        OP_READ_UNIQUE: begin
          ev_resp = {was_unique, 1'b0, dirty, 1'b0, 1'b1};
          ev_nst  = ST_I;
        end
        OP_CLEAN_INVALID: begin
          ev_resp = {was_unique, 1'b0, dirty, 1'b0, dirty};
          ev_nst  = ST_I;
        end
        OP_MAKE_INVALID: ev_nst = ST_I;
        default: ev_resp = 5'b00000;
      endcase
    end
    ev_pend = hit && (ev_nst != lk_state);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    AC_READY   = 1'b0;
    CR_VALID   = 1'b0;
    CR_RESP    = 5'b00000;
    CD_VALID   = 1'b0;
    CD_LAST    = 1'b0;
    CD_DATA    = '0;
    lk_valid   = 1'b0;
    lk_addr    = '0;
    upd_valid  = 1'b0;
    upd_addr   = '0;
    upd_state  = '0;
    snoop_busy = (state != IDLE);
    case (state)
      IDLE: begin
        // Held low while rst is asserted even though the FSM already sits in IDLE.
        AC_READY = !rst;
        if (AC_VALID) state_nxt = supported ? LOOKUP : RESP;
      end
      LOOKUP: begin
        lk_valid  = 1'b1;
        lk_addr   = addr_q;
        state_nxt = EVAL;
      end
      EVAL: state_nxt = RESP;
      RESP: begin
        CR_VALID = 1'b1;
        CR_RESP  = resp_q;
        if (CR_READY) begin
          if (resp_q[0])   state_nxt = DATA;
          else if (pend_q) state_nxt = UPDATE;
          else             state_nxt = IDLE;
        end
      end
      DATA: begin
        CD_VALID = 1'b1;
        CD_LAST  = 1'b1;
        CD_DATA  = data_q;
        if (CD_READY) state_nxt = pend_q ? UPDATE : IDLE;
      end
      UPDATE: begin
        upd_valid = 1'b1;
        upd_addr  = addr_q;
        upd_state = nst_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      snoop_q <= 4'b0000;
      resp_q  <= 5'b00000;
      data_q  <= '0;
      nst_q   <= '0;
      pend_q  <= 1'b0;
    end else if (state == IDLE && AC_VALID) begin
      addr_q  <= AC_ADDR;
      snoop_q <= AC_SNOOP;
      // Unsupported opcodes skip the lookup, so their response is settled here.
      resp_q  <= supported ? 5'b00000 : RESP_UNSUP;
      pend_q  <= 1'b0;
    end else if (state == EVAL) begin
      resp_q  <= ev_resp;
      data_q  <= lk_data;
      nst_q   <= ev_nst;
      pend_q  <= ev_pend;
    end
  end

endmodule
